// File: rtl/slt_pkg.sv
// Shared definitions for the sequential set-less-than responder: FSM encoding,
// default geometry and helpers that derive the compare-cycle count and counter width.
package slt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_DONE = 2'd2
  } slt_state_e;

  localparam int unsigned SLT_SIZE  = 32;
  localparam int unsigned SLT_DIGIT = 4;

  function automatic int unsigned cmp_cycles(input int unsigned size, input int unsigned digit);
    return size / digit;
  endfunction

  // A single-digit operand still needs a one-bit counter to stay a legal vector.
  function automatic int unsigned cnt_width(input int unsigned size, input int unsigned digit);
    int unsigned n;
    n = size / digit;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned SLT_CMP_CYCLES = cmp_cycles(SLT_SIZE, SLT_DIGIT);
  localparam int unsigned SLT_CNT_W      = cnt_width(SLT_SIZE, SLT_DIGIT);

endpackage

// File: rtl/slt_digit_cmp.sv
// Combinational DIGIT-bit unsigned comparator: reports a<b and a!=b for one slice.
module slt_digit_cmp
  import slt_pkg::*;
#(
  parameter int unsigned DIGIT = SLT_DIGIT
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  output logic             lt,
  output logic             ne
);

  assign lt = (a < b);
  assign ne = (a != b);

endmodule

// File: rtl/slt_seq_responder.sv
// Multi-cycle SLT/SLTU responder comparing DIGIT bits per cycle, MSB first.
// Define SLT_EARLY_EXIT_EN to finish at the first differing digit (variable latency).
module slt_seq_responder
  import slt_pkg::*;
#(
  parameter int unsigned SIZE  = SLT_SIZE,
  parameter int unsigned DIGIT = SLT_DIGIT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic            is_signed,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] out,
  output logic            busy
);

  localparam int unsigned CMP_CYCLES = cmp_cycles(SIZE, DIGIT);
  localparam int unsigned CNT_W      = cnt_width(SIZE, DIGIT);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CMP_CYCLES - 1);

  slt_state_e      state_q, state_d;
  logic [SIZE-1:0] sa_q, sa_d;
  logic [SIZE-1:0] sb_q, sb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic [SIZE-1:0] out_q, out_d;
  logic            busy_q, busy_d;
`ifndef SLT_EARLY_EXIT_EN
  logic            lt_q, lt_d;
  logic            decided_q, decided_d;
`endif

  logic dig_lt_s;
  logic dig_ne_s;

  slt_digit_cmp #(
    .DIGIT (DIGIT)
  ) u_digit_cmp (
    .a  (sa_q[SIZE-1 -: DIGIT]),
    .b  (sb_q[SIZE-1 -: DIGIT]),
    .lt (dig_lt_s),
    .ne (dig_ne_s)
  );

  // Next-state and next-output logic for the IDLE/CMP/DONE sequencer.
  always_comb begin
    state_d     = state_q;
    sa_d        = sa_q;
    sb_d        = sb_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    busy_d      = busy_q;
`ifndef SLT_EARLY_EXIT_EN
    lt_d        = lt_q;
    decided_d   = decided_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          // Flipping the sign bit maps two's-complement order onto unsigned order.
          sa_d           = a;
          sa_d[SIZE-1]   = a[SIZE-1] ^ is_signed;
          sb_d           = b;
          sb_d[SIZE-1]   = b[SIZE-1] ^ is_signed;
          cnt_d          = CNT_LOAD;
          state_d        = ST_CMP;
          in_ready_d     = 1'b0;
          busy_d         = 1'b1;
`ifndef SLT_EARLY_EXIT_EN
          lt_d           = 1'b0;
          decided_d      = 1'b0;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CMP: begin
`ifdef SLT_EARLY_EXIT_EN
        if (dig_ne_s || (cnt_q == {CNT_W{1'b0}})) begin
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
          out_d       = {{(SIZE-1){1'b0}}, dig_lt_s};
        end else begin
          sa_d  = sa_q << DIGIT;
          sb_d  = sb_q << DIGIT;
          cnt_d = cnt_q - CNT_W'(1);
        end
`else
        // Only the first differing digit decides; later digits cannot override it.
        if (!decided_q && dig_ne_s) begin
          lt_d      = dig_lt_s;
          decided_d = 1'b1;
        end else begin
          lt_d      = lt_q;
          decided_d = decided_q;
        end
        if (cnt_q == {CNT_W{1'b0}}) begin
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
          out_d       = {{(SIZE-1){1'b0}}, lt_d};
        end else begin
          sa_d  = sa_q << DIGIT;
          sb_d  = sb_q << DIGIT;
          cnt_d = cnt_q - CNT_W'(1);
        end
`endif
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          out_d       = {SIZE{1'b0}};
          busy_d      = 1'b0;
          in_ready_d  = 1'b1;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        out_d       = {SIZE{1'b0}};
        busy_d      = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  // State, datapath and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sa_q        <= {SIZE{1'b0}};
      sb_q        <= {SIZE{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_q       <= {SIZE{1'b0}};
      busy_q      <= 1'b0;
`ifndef SLT_EARLY_EXIT_EN
      lt_q        <= 1'b0;
      decided_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sa_q        <= sa_d;
      sb_q        <= sb_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      busy_q      <= busy_d;
`ifndef SLT_EARLY_EXIT_EN
      lt_q        <= lt_d;
      decided_q   <= decided_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_slt_seq_responder.sv
// Table-driven, scoreboarded bench for slt_seq_responder (SIZE=32, DIGIT=4).
module tb_slt_seq_responder;

  localparam int CMP_CYCLES = 8;
  localparam int NVEC       = 12;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        is_signed;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
  logic        busy;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit mon_en = 1'b0;
  logic ov_prev = 1'b0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic        lt;
    int          k;
  } vec_t;

  typedef struct {
    logic [31:0] out;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[NVEC];

  slt_seq_responder #(
    .SIZE  (32),
    .DIGIT (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .is_signed (is_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int exp_lat(input int k);
    int lat;
    lat = k;
`ifndef SLT_EARLY_EXIT_EN
    lat = CMP_CYCLES;
`endif
    return lat;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: scores each new result against the scoreboard and checks idle zeros.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (out_valid !== 1'b1) check("out_zero_when_invalid", out, 32'd0);
      if (out_valid === 1'b1 && ov_prev !== 1'b1) begin
        tests++;
        if (sb_q.size() == 0) begin
          fails++;
          $display("FAIL spurious_result: got out_valid=1 out=0x%0h, expected no result", out);
        end else begin
          e = sb_q.pop_front();
          check("result", out, e.out);
          check("latency", 32'(cyc - e.acc), 32'(e.lat));
          check("busy_in_done", {31'd0, busy}, 32'd1);
          check("in_ready_in_done", {31'd0, in_ready}, 32'd0);
        end
      end
    end
    ov_prev = out_valid;
  end

  task automatic issue(input logic [31:0] ta, input logic [31:0] tb_, input logic ts,
                       input logic [31:0] eout, input int lat, input bit push);
    int n;
    n = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_before_issue", {31'd0, in_ready}, 32'd1);
    a = ta;
    b = tb_;
    is_signed = ts;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (push) sb_q.push_back('{eout, lat, cyc});
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 40) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("result_timeout_pending", 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    a = 32'd0;
    b = 32'd0;
    is_signed = 1'b0;
    out_ready = 1'b1;

    vecs[0]  = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 8};
    vecs[1]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b1, 1};
    vecs[2]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1};
    vecs[3]  = '{32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0, 8};
    vecs[4]  = '{32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0, 8};
    vecs[5]  = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b1, 1};
    vecs[6]  = '{32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0, 1};
    vecs[7]  = '{32'h0000_1000, 32'h0000_2000, 1'b0, 1'b1, 5};
    vecs[8]  = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b1, 1'b1, 8};
    vecs[9]  = '{32'h0000_0010, 32'h0000_000F, 1'b0, 1'b0, 7};
    vecs[10] = '{32'h0000_0000, 32'h8000_0000, 1'b1, 1'b0, 1};
    vecs[11] = '{32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 1'b1, 1};

    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_out", out, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].s, {31'd0, vecs[i].lt}, exp_lat(vecs[i].k), 1'b1);
      drain();
    end

    // Backpressure: result held stable, stray in_valid ignored while not ready.
    out_ready = 1'b0;
    issue(32'd5, 32'd7, 1'b0, 32'd1, exp_lat(8), 1'b1);
    drain();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_out", out, 32'd1);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      if (i == 1) begin
        a = 32'd9;
        b = 32'd1;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("release_in_ready", {31'd0, in_ready}, 32'd1);
    check("release_out_valid", {31'd0, out_valid}, 32'd0);
    check("release_busy", {31'd0, busy}, 32'd0);
    repeat (12) @(posedge clk);

    // Reset mid-compare aborts the operation without producing a result.
    issue(32'd5, 32'd7, 1'b0, 32'd1, exp_lat(8), 1'b0);
    repeat (2) @(negedge clk);
    check("busy_during_cmp", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_out", out, 32'd0);
    repeat (12) @(posedge clk);

    issue(32'h8000_0000, 32'h0000_0000, 1'b0, 32'd0, exp_lat(1), 1'b1);
    drain();
    issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'd1, exp_lat(1), 1'b1);
    drain();

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
